// File: rtl/time_keeper_bcd.sv
// Real-time clock in packed BCD with run/stop/set control, driven by a 1 s toggle.
// Define HOUR12_EN for a 12-hour display with an afternoon flag; otherwise hours run 00-23.
module time_keeper_bcd (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       set_en,
    input  logic       set_load,
    input  logic [1:0] set_sel,
    input  logic [7:0] set_value,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic       day_pulse,
    output logic       set_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_SET  = 2'd2
    } state_t;

`ifdef HOUR12_EN
    localparam logic [7:0] HOUR_RESET = 8'h12;
`else
    localparam logic [7:0] HOUR_RESET = 8'h00;
`endif

    state_t     cur_state;
    state_t     nxt_state;
    logic       sync_q1;
    logic       sync_q2;
    logic       tick_prev;
    logic       tick_pulse;
    logic       run_tick;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_advance;
    logic       day_roll;
    logic       digits_ok;
    logic       ms_ok;
    logic       hour_ok;
    logic       set_ok;
    logic [7:0] hour_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Every level change of tick_in is one second, so the detector fires on both edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            tick_prev <= 1'b0;
        end else begin
            sync_q1   <= tick_in;
            sync_q2   <= sync_q1;
            tick_prev <= sync_q2;
        end
    end

    assign tick_pulse = sync_q2 ^ tick_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_state <= ST_STOP;
        else
            cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (set_en) begin
            nxt_state = ST_SET;
        end else begin
            case (cur_state)
                ST_STOP: if (start && !stop) nxt_state = ST_RUN;
                ST_RUN:  if (stop)           nxt_state = ST_STOP;
                default:                     nxt_state = ST_STOP;
            endcase
        end
    end

    assign state        = cur_state;
    assign run_tick     = (cur_state == ST_RUN) && tick_pulse;
    assign sec_wrap     = (sec_bcd == 8'h59);
    assign min_wrap     = (min_bcd == 8'h59);
    assign hour_advance = run_tick && sec_wrap && min_wrap;

    // With valid digits, packed BCD orders the same as the decimal value.
    assign digits_ok = (set_value[7:4] <= 4'd9) && (set_value[3:0] <= 4'd9);
    assign ms_ok     = digits_ok && (set_value <= 8'h59);

`ifdef HOUR12_EN
    logic pm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pm_q <= 1'b0;
        else if (hour_advance && hour_bcd == 8'h11)
            pm_q <= ~pm_q;
    end

    assign pm      = pm_q;
    assign hour_ok = digits_ok && (set_value >= 8'h01) && (set_value <= 8'h12);

    always_comb begin
        hour_next = bcd_inc(hour_bcd);
        day_roll  = 1'b0;
        if (hour_bcd == 8'h12)
            hour_next = 8'h01;
        else if (hour_bcd == 8'h11)
            day_roll = pm_q;
    end
`else
    assign pm      = 1'b0;
    assign hour_ok = digits_ok && (set_value <= 8'h23);

    always_comb begin
        hour_next = bcd_inc(hour_bcd);
        day_roll  = 1'b0;
        if (hour_bcd == 8'h23) begin
            hour_next = 8'h00;
            day_roll  = 1'b1;
        end
    end
`endif

    always_comb begin
        case (set_sel)
            2'd0, 2'd1: set_ok = ms_ok;
            2'd2:       set_ok = hour_ok;
            default:    set_ok = 1'b1;
        endcase
    end

    // Time only moves in RUN; loads only land in SET, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_bcd   <= 8'h00;
            min_bcd   <= 8'h00;
            hour_bcd  <= HOUR_RESET;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
            if (run_tick) begin
                sec_bcd <= sec_wrap ? 8'h00 : bcd_inc(sec_bcd);
                if (sec_wrap) begin
                    min_bcd <= min_wrap ? 8'h00 : bcd_inc(min_bcd);
                    if (min_wrap) begin
                        hour_bcd  <= hour_next;
                        day_pulse <= day_roll;
                    end
                end
            end else if (cur_state == ST_SET && set_load) begin
                if (!set_ok) begin
                    set_err <= 1'b1;
                end else begin
                    case (set_sel)
                        2'd0:    sec_bcd  <= set_value;
                        2'd1:    min_bcd  <= set_value;
                        2'd2:    hour_bcd <= set_value;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
